// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised serial pattern detector.
// Transition targets are resolved at elaboration from the pattern itself.
package seq_det_pkg;

    localparam int MAX_LEN = 16;

    function automatic int sw_of(input int len);
        return $clog2(len + 1);
    endfunction

    // KMP-style fallback: longest pattern prefix that is a suffix of history
    function automatic int next_state(
        input logic [MAX_LEN-1:0] pattern,
        input int                 len,
        input int                 k,
        input logic               b,
        input logic               overlap
    );
        logic [MAX_LEN:0] s;
        int               best;
        logic             ok;
        if (k > len) begin
            return 0;
        end
        if (k == len && !overlap) begin
            return (b == pattern[4'(len - 1)]) ? 1 : 0;
        end
        s = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < k) begin
                s[5'(i)] = pattern[4'(len - 1 - i)];
            end
        end
        s[5'(k)] = b;
        best = 0;
        for (int j = 1; j <= MAX_LEN; j++) begin
            if (j <= len && j <= k + 1) begin
                ok = 1'b1;
                for (int t = 0; t < MAX_LEN; t++) begin
                    if (t < j) begin
                        if (s[5'(k + 1 - j + t)] != pattern[4'(len - 1 - t)]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_detector_moore_param_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_moore_param.sv
// Moore detector for an arbitrary PAT_LEN-bit serial pattern.
// Next-state table is elaborated from PATTERN; out decodes the MATCH state.
module seq_detector_moore_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b11011,
    parameter bit                 OVERLAP = 1'b0,
    parameter int                 CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        clr,
    input  logic                        in,
    output logic                        out,
    output logic [sw_of(PAT_LEN)-1:0]   state_o,
    output logic [CNT_W-1:0]            match_cnt
);

    localparam int            SW    = sw_of(PAT_LEN);
    localparam int            NS    = 2 ** SW;
    localparam logic [SW-1:0] MATCH = SW'(PAT_LEN);

    logic [SW-1:0] nxt0 [NS];
    logic [SW-1:0] nxt1 [NS];

    for (genvar k = 0; k < NS; k++) begin : g_tbl
        localparam logic [SW-1:0] N0 = SW'(next_state(
            MAX_LEN'(PATTERN), PAT_LEN, k, 1'b0, OVERLAP));
        localparam logic [SW-1:0] N1 = SW'(next_state(
            MAX_LEN'(PATTERN), PAT_LEN, k, 1'b1, OVERLAP));
        assign nxt0[k] = N0;
        assign nxt1[k] = N1;
    end

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic          inc;

    always_comb begin
        state_d = state_q;
        inc     = 1'b0;
        if (clr) begin
            state_d = '0;
        end else if (en) begin
            state_d = in ? nxt1[state_q] : nxt0[state_q];
            inc     = (state_d == MATCH);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign out     = (state_q == MATCH);
    assign state_o = state_q;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .inc(inc),
        .cnt(match_cnt)
    );

endmodule

// File: tb/tb_seq_detector_moore_param.sv
// Directed bench for seq_detector_moore_param across three parameter sets.
module tb_seq_detector_moore_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic in = 1'b0;

    logic       a_out;
    logic [2:0] a_state;
    logic [7:0] a_cnt;
    logic       b_out;
    logic [2:0] b_state;
    logic [7:0] b_cnt;
    logic       c_out;
    logic [1:0] c_state;
    logic [1:0] c_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detector_moore_param dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .in(in),
        .out(a_out), .state_o(a_state), .match_cnt(a_cnt)
    );

    seq_detector_moore_param #(
        .OVERLAP(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .in(in),
        .out(b_out), .state_o(b_state), .match_cnt(b_cnt)
    );

    seq_detector_moore_param #(
        .PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)
    ) dut_c (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .in(in),
        .out(c_out), .state_o(c_state), .match_cnt(c_cnt)
    );

    task automatic step(input logic b, input logic e);
        in = b;
        en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step(1'b0, 1'b1);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        checks++;
        if ({a_out, a_state, a_cnt} !== 12'd0) begin
            errors++;
            $display("FAIL reset_a got %b %0d %0d want 0 0 0", a_out, a_state, a_cnt);
        end
        checks++;
        if ({b_out, b_state, b_cnt} !== 12'd0) begin
            errors++;
            $display("FAIL reset_b got %b %0d %0d want 0 0 0", b_out, b_state, b_cnt);
        end
        checks++;
        if ({c_out, c_state, c_cnt} !== 5'd0) begin
            errors++;
            $display("FAIL reset_c got %b %0d %0d want 0 0 0", c_out, c_state, c_cnt);
        end
        rst = 1'b1;
    endtask

    task automatic test_overlap_modes();
        logic [7:0] s;
        logic [7:0] ea;
        logic [7:0] eb;
        s  = 8'b11011011;
        ea = 8'b00001000;
        eb = 8'b00001001;
        do_clr();
        for (int i = 0; i < 8; i++) begin
            step(s[7-i], 1'b1);
            checks++;
            if (a_out !== ea[7-i]) begin
                errors++;
                $display("FAIL nonovl_out bit%0d got %b want %b", i + 1, a_out, ea[7-i]);
            end
            checks++;
            if (b_out !== eb[7-i]) begin
                errors++;
                $display("FAIL ovl_out bit%0d got %b want %b", i + 1, b_out, eb[7-i]);
            end
        end
        checks++;
        if (a_state !== 3'd2 || a_cnt !== 8'd1) begin
            errors++;
            $display("FAIL nonovl_end got S%0d cnt %0d want S2 cnt 1", a_state, a_cnt);
        end
        checks++;
        if (b_state !== 3'd5 || b_cnt !== 8'd2) begin
            errors++;
            $display("FAIL ovl_end got S%0d cnt %0d want S5 cnt 2", b_state, b_cnt);
        end
        checks++;
        if (c_state !== 2'd2 || c_cnt !== 2'd3) begin
            errors++;
            $display("FAIL pat11_end got S%0d cnt %0d want S2 cnt 3", c_state, c_cnt);
        end
    endtask

    task automatic test_kmp_fallback();
        logic [5:0] s;
        logic [2:0] es [6];
        s  = 6'b111011;
        es = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5};
        do_clr();
        for (int i = 0; i < 6; i++) begin
            step(s[5-i], 1'b1);
            checks++;
            if (a_state !== es[i] || a_out !== (i == 5)) begin
                errors++;
                $display("FAIL kmp bit%0d got S%0d out %b want S%0d", i + 1, a_state, a_out, es[i]);
            end
        end
    endtask

    task automatic test_en_gap();
        do_clr();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if (a_state !== 3'd2) begin
                errors++;
                $display("FAIL gap_hold cyc%0d got S%0d want S2", i, a_state);
            end
        end
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if (a_out !== 1'b1 || a_cnt !== 8'd1) begin
                errors++;
                $display("FAIL gap_match cyc%0d got out %b cnt %0d want 1 1", i, a_out, a_cnt);
            end
        end
        step(1'b0, 1'b1);
        checks++;
        if (a_out !== 1'b0 || a_state !== 3'd0) begin
            errors++;
            $display("FAIL gap_after got out %b S%0d want 0 S0", a_out, a_state);
        end
    endtask

    task automatic test_mid_restart(input logic use_clr);
        logic [8:0] s;
        s = 9'b110111101;
        do_clr();
        for (int i = 0; i < 9; i++) begin
            step(s[8-i], 1'b1);
        end
        checks++;
        if (a_state !== 3'd4 || a_cnt !== 8'd1) begin
            errors++;
            $display("FAIL pre_restart clr=%b got S%0d cnt %0d want S4 1", use_clr, a_state, a_cnt);
        end
        if (use_clr) begin
            clr = 1'b1;
            step(1'b1, 1'b0);
            clr = 1'b0;
        end else begin
            rst = 1'b0;
            step(1'b1, 1'b1);
            rst = 1'b1;
        end
        checks++;
        if (a_state !== 3'd0 || a_out !== 1'b0 || a_cnt !== 8'd0) begin
            errors++;
            $display("FAIL restart clr=%b got S%0d out %b cnt %0d want S0 0 0", use_clr, a_state, a_out, a_cnt);
        end
        step(1'b1, 1'b1);
        checks++;
        if (a_state !== 3'd1 || a_out !== 1'b0 || a_cnt !== 8'd0) begin
            errors++;
            $display("FAIL post_restart clr=%b got S%0d out %b cnt %0d want S1 0 0", use_clr, a_state, a_out, a_cnt);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] es [6];
        logic [1:0] ec [6];
        es = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
        ec = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_clr();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if (c_state !== es[i] || c_cnt !== ec[i] || c_out !== (i >= 1)) begin
                errors++;
                $display("FAIL sat bit%0d got S%0d cnt %0d out %b want S%0d cnt %0d",
                         i + 1, c_state, c_cnt, c_out, es[i], ec[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap_modes();
        test_kmp_fallback();
        test_en_gap();
        test_mid_restart(1'b0);
        test_mid_restart(1'b1);
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
